uart_tx_buffered: RTL and testbench

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_pkg.sv | 18 +
 rtl/byte_fifo.sv | 76 +++++++
 rtl/uart_tx_buffered.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver.
//   DEFAULT_BIT_PERIOD : clocks per UART bit (12 MHz / 9600 baud)
//   uart_state_t       : frame FSM state encoding (IDLE, START, DATA, STOP)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DEFAULT_BIT_PERIOD = 1250;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Synchronous byte FIFO with a show-ahead head output and a flush.
//   DEPTH    : number of byte entries, power of two (2..256)
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset (pointers and count only)
//   i_push   : write i_data; ignored while full or flushing
//   i_data   : byte to write
//   i_pop    : drop the head entry; ignored while empty or flushing
//   i_flush  : empty the FIFO on this edge, overriding push and pop
//   o_data   : current head entry (valid while o_count != 0)
//   o_count  : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [7:0]               i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [7:0]               o_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Full/empty decisions use the registered count only, so a full FIFO
    // refuses a write even when a pop happens on the same edge.
    assign w_push_ok = i_push && (r_count < CNT_W'(DEPTH)) && !i_flush;
    assign w_pop_ok  = i_pop  && (r_count != '0)           && !i_flush;

    // NOTE: storage has no reset so synthesis can map it onto RAM; stale
    // contents are never observed because the count gates every read.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH.
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
// 8N1 UART transmitter fed from a byte FIFO; back-to-back frames with no gap.
//   BIT_PERIOD : clocks per UART bit
//   FIFO_DEPTH : FIFO entries, power of two (2..256)
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   wr_data    : byte to enqueue
//   wr_valid   : producer offers wr_data this cycle
//   wr_ready   : FIFO can accept a byte this cycle
//   flush      : discard queued bytes; the frame in flight still completes
//   tx_pin     : registered serial output, idle high
//   busy       : frame in flight or bytes queued
//   fifo_count : queued bytes, excluding the one being shifted
// -----------------------------------------------------------------------------
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int BIT_PERIOD = DEFAULT_BIT_PERIOD,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic                          flush,
    output logic                          tx_pin,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CLK_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CLK_W-1:0] LAST_CLK = CLK_W'(BIT_PERIOD - 1);

    uart_state_t      r_state;
    uart_state_t      w_state_nxt;
    logic [CLK_W-1:0] r_clk_cnt;
    logic [CLK_W-1:0] w_clk_nxt;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_tx;
    logic             w_tx_nxt;
    logic             w_pop;
    logic [7:0]       w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_bit_done;
    logic             w_queued;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (wr_valid && wr_ready),
        .i_data  (wr_data),
        .i_pop   (w_pop),
        .i_flush (flush),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign w_bit_done = (r_clk_cnt == LAST_CLK);
    assign w_queued   = (w_count != '0);

    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_clk_nxt   = r_clk_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tx_nxt  = 1'b1;
                w_clk_nxt = '0;
                if (w_queued) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    // The shifter always presents the next data bit at [0].
                    w_clk_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_state_nxt = ST_DATA;
                end else begin
                    w_clk_nxt = r_clk_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    w_clk_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_nxt   = r_bit_idx + 1'b1;
                        w_tx_nxt    = r_shift[0];
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_clk_nxt = r_clk_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    w_clk_nxt = '0;
                    // Chain straight into the next start bit: no idle gap.
                    if (w_queued) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_clk_nxt = r_clk_cnt + 1'b1;
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_clk_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    assign tx_pin     = r_tx;
    assign wr_ready   = (w_count < CNT_W'(FIFO_DEPTH));
    assign busy       = (r_state != ST_IDLE) || w_queued;
    assign fifo_count = w_count;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffered
// Directed bench for uart_tx_buffered at BIT_PERIOD=4, FIFO_DEPTH=16.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A recorder logs tx_pin/busy every falling edge of a window, and the window
// is compared against 8N1 waveforms built from the expected byte list.
// -----------------------------------------------------------------------------
module tb_uart_tx_buffered;

    localparam int BP    = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * BP;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic [7:0] wr_data  = 8'h00;
    logic       wr_valid = 1'b0;
    logic       flush    = 1'b0;
    logic       wr_ready;
    logic       tx_pin;
    logic       busy;
    logic [4:0] fifo_count;

    int checks = 0;
    int errors = 0;

    // Recorder window: samples are appended while size < rec_end.
    logic       rec_tx   [$];
    logic       rec_busy [$];
    int         rec_base = 0;
    int         rec_end  = 0;
    int         rec_len  = 0;
    int         rec_trail = 0;
    logic [7:0] exp_bytes [$];

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .BIT_PERIOD (BP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .flush      (flush),
        .tx_pin     (tx_pin),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always @(negedge clk) begin
        if (rec_tx.size() < rec_end) begin
            rec_tx.push_back(tx_pin);
            rec_busy.push_back(busy);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Call on the posedge that accepts the first byte of exp_bytes. The window
    // holds one idle sample, the frames, then `trail` idle samples.
    task automatic start_rec(input int trail);
        rec_trail = trail;
        rec_len   = 1 + FRAME * exp_bytes.size() + trail;
        rec_base  = rec_tx.size();
        rec_end   = rec_base + rec_len;
    endtask

    task automatic check_wave(input string tag);
        int   bad;
        int   nb;
        int   f;
        int   b;
        logic etx;
        logic ebusy;
        for (int t = 0; t < 5000 && rec_tx.size() < rec_end; t++) @(negedge clk);
        @(posedge clk);
        check({tag, "_samples"}, 32'(rec_tx.size() - rec_base), 32'(rec_len));
        bad = -1;
        nb  = exp_bytes.size();
        for (int i = 0; i < rec_len && rec_base + i < rec_tx.size(); i++) begin
            if (i == 0) begin
                etx   = 1'b1;
                ebusy = 1'b1;
            end else if (i <= FRAME * nb) begin
                f     = (i - 1) / FRAME;
                b     = ((i - 1) % FRAME) / BP;
                etx   = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_bytes[f][b-1];
                ebusy = 1'b1;
            end else begin
                etx   = 1'b1;
                ebusy = 1'b0;
            end
            if (bad < 0 && (rec_tx[rec_base+i] !== etx || rec_busy[rec_base+i] !== ebusy)) bad = i;
        end
        check({tag, "_first_bad_sample"}, 32'(bad), 32'hFFFF_FFFF);
    endtask

    initial begin
        int sent;
        int quiet_bad;

        // ---- reset state ----
        #2 rst_n = 1'b0;
        #1;
        check("rst_tx_pin",     32'(tx_pin),     32'd1);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_wr_ready",   32'(wr_ready),   32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---- single byte 0x55: 40 clocks, busy drops afterwards ----
        wr_data = 8'h55; wr_valid = 1'b1;
        @(posedge clk);
        exp_bytes = {8'h55};
        start_rec(1);
        @(negedge clk);
        wr_valid = 1'b0;
        check("t30_count_after_push", 32'(fifo_count), 32'd1);
        check("t30_busy_queued",      32'(busy),       32'd1);
        check_wave("t30_wave");

        // ---- three back-to-back bytes, no gap between frames ----
        @(negedge clk);
        wr_data = 8'h41; wr_valid = 1'b1;
        @(posedge clk);
        exp_bytes = {8'h41, 8'h42, 8'h43};
        start_rec(1);
        @(negedge clk); wr_data = 8'h42;
        @(negedge clk); wr_data = 8'h43;
        @(negedge clk); wr_valid = 1'b0;
        check("t31_count_two_queued", 32'(fifo_count), 32'd2);
        check_wave("t31_wave");

        // ---- hold wr_valid: 1 in flight + 16 queued, full FIFO vs pop ----
        @(negedge clk);
        wr_data = 8'h60; wr_valid = 1'b1; sent = 1;
        @(posedge clk);
        exp_bytes.delete();
        for (int k = 0; k < 17; k++) exp_bytes.push_back(8'h60 + 8'(k));
        start_rec(1);
        for (int m = 0; m <= 41; m++) begin
            @(negedge clk);
            if (m == 20) begin
                check("t32_count_full",     32'(fifo_count), 32'd16);
                check("t32_ready_low_full", 32'(wr_ready),   32'd0);
            end
            if (m == 40) begin
                check("t33_count_before_pop", 32'(fifo_count), 32'd16);
                check("t33_ready_before_pop", 32'(wr_ready),   32'd0);
            end
            if (m == 41) begin
                check("t33_count_after_pop", 32'(fifo_count), 32'd15);
                check("t33_ready_after_pop", 32'(wr_ready),   32'd1);
                wr_valid = 1'b0;
            end else if (wr_ready && sent < 17) begin
                wr_data = 8'h60 + 8'(sent);
                sent++;
            end else begin
                wr_data = 8'hEE;
            end
        end
        check_wave("t32_wave");

        // ---- flush during first of five frames, with a dropped push ----
        @(negedge clk);
        wr_data = 8'h11; wr_valid = 1'b1;
        @(posedge clk);
        exp_bytes = {8'h11};
        start_rec(30);
        @(negedge clk); wr_data = 8'h22;
        @(negedge clk); wr_data = 8'h33;
        @(negedge clk); wr_data = 8'h44;
        @(negedge clk); wr_data = 8'h55;
        @(negedge clk); wr_valid = 1'b0;
        check("t35_count_before_flush", 32'(fifo_count), 32'd4);
        repeat (5) @(negedge clk);
        flush = 1'b1; wr_valid = 1'b1; wr_data = 8'h99;
        @(negedge clk);
        flush = 1'b0; wr_valid = 1'b0;
        check("t35_count_after_flush", 32'(fifo_count), 32'd0);
        check("t35_busy_in_flight",    32'(busy),       32'd1);
        check_wave("t35_wave");

        // ---- reset during data bit 3 of 0xA5 with 0x3C queued ----
        @(negedge clk);
        wr_data = 8'hA5; wr_valid = 1'b1;
        @(negedge clk); wr_data = 8'h3C;
        @(negedge clk); wr_valid = 1'b0;
        repeat (18) @(negedge clk);
        check("t34_bit3_level", 32'(tx_pin),     32'd0);
        check("t34_count_pre",  32'(fifo_count), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t34_tx_high_in_reset", 32'(tx_pin),     32'd1);
        check("t34_count_zero",       32'(fifo_count), 32'd0);
        check("t34_busy_low",         32'(busy),       32'd0);
        check("t34_ready_high",       32'(wr_ready),   32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        quiet_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_pin !== 1'b1 || busy !== 1'b0) quiet_bad++;
        end
        check("t34_quiet_after_release", 32'(quiet_bad), 32'd0);

        // First write after reset must be the first byte sent.
        wr_data = 8'h5A; wr_valid = 1'b1;
        @(posedge clk);
        exp_bytes = {8'h5A};
        start_rec(1);
        @(negedge clk);
        wr_valid = 1'b0;
        check_wave("t34_first_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
